// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller client port: serves write/read
// commands after fixed latencies and stalls periodically to mimic refresh.
module sdram_bram_responder #(
  parameter int ADDR_WIDTH     = 22,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int WRITE_LATENCY  = 2,
  parameter int READ_LATENCY   = 3,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            command,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [15:0]           data_write,
  output logic [15:0]           data_read,
  output logic                  data_ready,
  output logic                  data_next
);

  localparam int LAT_WR_RD = (WRITE_LATENCY > READ_LATENCY) ? WRITE_LATENCY : READ_LATENCY;
  localparam int WAIT_MAX  = (LAT_WR_RD > REFRESH_CYCLES) ? LAT_WR_RD : REFRESH_CYCLES;
  localparam int WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam int REF_W     = $clog2(REFRESH_PERIOD);
  localparam int MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;

  localparam logic [WAIT_W-1:0] WR_DONE  = WAIT_W'(WRITE_LATENCY);
  localparam logic [WAIT_W-1:0] RD_DONE  = WAIT_W'(READ_LATENCY);
  localparam logic [WAIT_W-1:0] REF_DONE = WAIT_W'(REFRESH_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_PERIOD - 1);
  localparam logic [REF_W-1:0]  REF_ONE  = REF_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE_WAIT = 2'd1,
    ST_READ_WAIT  = 2'd2,
    ST_REFRESH    = 2'd3
  } state_t;

  state_t                    state_r, state_s;
  logic [WAIT_W-1:0]         wait_r;
  logic [REF_W-1:0]          ref_cnt_r;
  logic                      refresh_pend_r;
  logic [MEM_ADDR_WIDTH-1:0] addr_r, rd_addr_s;
  logic [15:0]               wdata_r;
  logic [15:0]               mem_q_r;
  logic [15:0]               mem_r [0:MEM_DEPTH-1];
  logic                      accept_s, refresh_take_s, wr_commit_s, rd_done_s;
  logic                      data_ready_s, data_next_s;
  logic                      unused_addr_hi_s;

  // Only the low address bits select a BRAM word.
  assign unused_addr_hi_s = ^data_address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  // State, counters, latched request and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      wait_r         <= {WAIT_W{1'b0}};
      ref_cnt_r      <= {REF_W{1'b0}};
      refresh_pend_r <= 1'b0;
      addr_r         <= {MEM_ADDR_WIDTH{1'b0}};
      wdata_r        <= 16'h0000;
      data_read      <= 16'h0000;
      data_ready     <= 1'b0;
      data_next      <= 1'b0;
    end else begin
      state_r    <= state_s;
      data_ready <= data_ready_s;
      data_next  <= data_next_s;
      if (state_s == ST_IDLE) begin
        wait_r <= {WAIT_W{1'b0}};
      end else if (state_r == ST_IDLE) begin
        wait_r <= WAIT_ONE;
      end else begin
        wait_r <= wait_r + WAIT_ONE;
      end
      if (accept_s) begin
        addr_r  <= data_address[MEM_ADDR_WIDTH-1:0];
        wdata_r <= data_write;
      end
      if (rd_done_s) begin
        data_read <= mem_q_r;
      end
      // A wrap always wins, so overlapping wraps collapse into one pending refresh.
      if (ref_cnt_r == REF_LAST) begin
        ref_cnt_r      <= {REF_W{1'b0}};
        refresh_pend_r <= 1'b1;
      end else begin
        ref_cnt_r <= ref_cnt_r + REF_ONE;
        if (refresh_take_s) begin
          refresh_pend_r <= 1'b0;
        end
      end
    end
  end

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (refresh_pend_r) begin
          state_s = ST_REFRESH;
        end else if (command == 2'd1) begin
          state_s = ST_WRITE_WAIT;
        end else if (command == 2'd2) begin
          state_s = ST_READ_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE_WAIT: state_s = (wait_r == WR_DONE)  ? ST_IDLE : ST_WRITE_WAIT;
      ST_READ_WAIT:  state_s = (wait_r == RD_DONE)  ? ST_IDLE : ST_READ_WAIT;
      ST_REFRESH:    state_s = (wait_r == REF_DONE) ? ST_IDLE : ST_REFRESH;
      default:       state_s = ST_IDLE;
    endcase
  end

  // Per-state strobes and next output values
  always_comb begin
    accept_s       = 1'b0;
    refresh_take_s = 1'b0;
    wr_commit_s    = 1'b0;
    rd_done_s      = 1'b0;
    data_ready_s   = 1'b0;
    data_next_s    = 1'b0;
    rd_addr_s      = addr_r;
    case (state_r)
      ST_IDLE: begin
        // Read the incoming address so the BRAM output is ready one cycle after accept.
        rd_addr_s = data_address[MEM_ADDR_WIDTH-1:0];
        if (refresh_pend_r) begin
          refresh_take_s = 1'b1;
        end else if ((command == 2'd1) || (command == 2'd2)) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_WRITE_WAIT: begin
        if (wait_r == WR_DONE) begin
          wr_commit_s = 1'b1;
          data_next_s = 1'b1;
        end else begin
          wr_commit_s = 1'b0;
          data_next_s = 1'b0;
        end
      end
      ST_READ_WAIT: begin
        if (wait_r == RD_DONE) begin
          rd_done_s    = 1'b1;
          data_ready_s = 1'b1;
          data_next_s  = 1'b1;
        end else begin
          rd_done_s    = 1'b0;
          data_ready_s = 1'b0;
          data_next_s  = 1'b0;
        end
      end
      default: begin
        rd_addr_s = addr_r;
      end
    endcase
  end

  // Block RAM: synchronous write, registered read, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      mem_r[addr_r] <= wdata_r;
    end
    mem_q_r <= mem_r[rd_addr_s];
  end

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench for sdram_bram_responder: a vector table of single accesses
// plus hand-written sequences for back-to-back, refresh, reset and command 3.
module tb_sdram_bram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  command;
  logic [21:0] data_address;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic        data_ready;
  logic        data_next;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sdram_bram_responder #(
    .ADDR_WIDTH(22), .MEM_ADDR_WIDTH(10), .WRITE_LATENCY(2),
    .READ_LATENCY(3), .REFRESH_PERIOD(780), .REFRESH_CYCLES(8)
  ) dut (
    .clk(clk), .resetn(resetn), .command(command), .data_address(data_address),
    .data_write(data_write), .data_read(data_read), .data_ready(data_ready),
    .data_next(data_next)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [21:0] addr;
    logic [15:0] wdata;
    int          exp_lat;
    logic        exp_rdy;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Waits for data_next; lat is edges after the first edge (the accept edge).
  task automatic wait_pulse(input bit clear_cmd, input int max_k, output int lat,
                            output logic rdy, output logic [15:0] rd);
    lat = -1;
    rdy = 1'b0;
    rd  = 16'h0000;
    for (int i = 1; i <= max_k; i++) begin
      @(negedge clk);
      if (i == 1 && clear_cmd) begin
        command      = 2'd0;
        data_address = ~data_address;
        data_write   = ~data_write;
      end
      if (data_next) begin
        lat = i - 1;
        rdy = data_ready;
        rd  = data_read;
        break;
      end
    end
  endtask

  task automatic access(input logic [1:0] cmd, input logic [21:0] a, input logic [15:0] wd,
                        output int lat, output logic rdy, output logic [15:0] rd);
    command      = cmd;
    data_address = a;
    data_write   = wd;
    wait_pulse(1'b1, 20, lat, rdy, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    command = 2'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int          lat;
    logic        rdy;
    logic [15:0] rd;
    int          npulse;
    int          ptime[2];
    logic [15:0] pdata[2];
    int          cnt;

    vecs[0] = '{2'd1, 22'h0CAFEE, 16'hFACE, 2, 1'b0, 16'h0000};
    vecs[1] = '{2'd2, 22'h0CAFEE, 16'h0000, 3, 1'b1, 16'hFACE};
    vecs[2] = '{2'd1, 22'h000001, 16'h1234, 2, 1'b0, 16'hFACE};
    vecs[3] = '{2'd1, 22'h3FF401, 16'h5678, 2, 1'b0, 16'hFACE};
    vecs[4] = '{2'd2, 22'h000001, 16'h0000, 3, 1'b1, 16'h5678};
    vecs[5] = '{2'd1, 22'h0003FF, 16'hABCD, 2, 1'b0, 16'h5678};
    vecs[6] = '{2'd2, 22'h3FFFFF, 16'h0000, 3, 1'b1, 16'hABCD};
    vecs[7] = '{2'd2, 22'h0003EE, 16'h0000, 3, 1'b1, 16'hFACE};

    resetn       = 1'b0;
    command      = 2'd0;
    data_address = 22'h0;
    data_write   = 16'h0;
    #1;
    check("reset data_read", 32'(data_read), 32'h0);
    check("reset data_ready", 32'(data_ready), 32'h0);
    check("reset data_next", 32'(data_next), 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle data_next", 32'(data_next), 32'h0);

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, lat, rdy, rd);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d data_ready", i), 32'(rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d data_read", i), 32'(rd), 32'(vecs[i].exp_rd));
    end

    // Held read command, address switched mid-access.
    command      = 2'd2;
    data_address = 22'h0CAFEE;
    npulse       = 0;
    ptime        = '{0, 0};
    pdata        = '{16'h0, 16'h0};
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) data_address = 22'h000001;
      if (data_next) begin
        if (npulse < 2) begin
          ptime[npulse] = i;
          pdata[npulse] = data_read;
        end
        npulse++;
      end
      if (i == 8) command = 2'd0;
    end
    check("b2b pulse count", 32'(npulse), 32'd2);
    check("b2b first pulse", 32'(ptime[0]), 32'd4);
    check("b2b second pulse", 32'(ptime[1]), 32'd8);
    check("b2b first data", 32'(pdata[0]), 32'hFACE);
    check("b2b second data", 32'(pdata[1]), 32'h5678);

    // Reserved command 3 must do nothing.
    command      = 2'd3;
    data_address = 22'h0003EE;
    data_write   = 16'hDEAD;
    cnt          = 0;
    repeat (20) begin
      @(negedge clk);
      if (data_next || data_ready) cnt++;
    end
    check("cmd3 pulses", 32'(cnt), 32'd0);
    check("cmd3 data_read held", 32'(data_read), 32'h5678);
    command = 2'd0;
    access(2'd2, 22'h0003EE, 16'h0, lat, rdy, rd);
    check("cmd3 bram unchanged", 32'(rd), 32'hFACE);

    // Reset one cycle into WRITE_WAIT aborts the write.
    command      = 2'd1;
    data_address = 22'h0003EE;
    data_write   = 16'h0BAD;
    @(negedge clk);
    command = 2'd0;
    resetn  = 1'b0;
    #1;
    check("abort data_read", 32'(data_read), 32'h0);
    check("abort data_next", 32'(data_next), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (data_next || data_ready) cnt++;
    end
    check("abort no pulse", 32'(cnt), 32'd0);
    access(2'd2, 22'h0003EE, 16'h0, lat, rdy, rd);
    check("abort old data", 32'(rd), 32'hFACE);
    check("abort read latency", 32'(lat), 32'd3);

    // Read presented while refresh is pending: 8 refresh cycles, then accept.
    do_reset();
    repeat (780) @(negedge clk);
    command      = 2'd2;
    data_address = 22'h000001;
    wait_pulse(1'b0, 20, lat, rdy, rd);
    command = 2'd0;
    check("refresh-first latency", 32'(lat), 32'd12);
    check("refresh-first data_ready", 32'(rdy), 32'h1);
    check("refresh-first data", 32'(rd), 32'h5678);

    // Refresh wraps during READ_WAIT: read on time, refresh right after.
    do_reset();
    repeat (778) @(negedge clk);
    access(2'd2, 22'h0003FF, 16'h0, lat, rdy, rd);
    check("wrap-in-read latency", 32'(lat), 32'd3);
    check("wrap-in-read data", 32'(rd), 32'hABCD);
    command      = 2'd2;
    data_address = 22'h0CAFEE;
    wait_pulse(1'b0, 20, lat, rdy, rd);
    command = 2'd0;
    check("post-read refresh latency", 32'(lat), 32'd12);
    check("post-read refresh data", 32'(rd), 32'hFACE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
